// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit front-end:
// register map, STATUS/CTRL bit positions and the drain FSM states.
package uart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_DRAIN = 4;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_OVF = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Register bus from the CPU plus the load handshake toward the UART transmitter.
interface uart_tx_fifo_if;

    // Handshake: bus_wr/bus_rd are single-cycle strobes with bus_addr/bus_wdata
    // valid in the same cycle; bus_rdata answers a read one cycle later and
    // holds otherwise. tx_write_en is a one-cycle load pulse with tx_data valid
    // alongside it; a new pulse is only issued while tx_busy is low.
    logic        bus_wr;
    logic        bus_rd;
    logic [1:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [15:0] bus_rdata;
    logic        tx_write_en;
    logic [7:0]  tx_data;
    logic        tx_busy;

    modport master (
        output bus_wr, bus_rd, bus_addr, bus_wdata, tx_busy,
        input  bus_rdata, tx_write_en, tx_data
    );

    modport slave (
        input  bus_wr, bus_rd, bus_addr, bus_wdata, tx_busy,
        output bus_rdata, tx_write_en, tx_data
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output, flush and occupancy count.
module sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// CPU-facing transmit queue: register decode, byte FIFO and a drain FSM that
// feeds the UART transmitter one byte per write_en pulse.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic   clk,
    input  logic   rst,
    uart_tx_fifo_if.slave bus,
    output state_t dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_next;
    logic             load;
    logic             overflow;
    logic             write_en_q;
    logic [7:0]       data_q;
    logic [15:0]      rdata_q;
    logic [7:0]       head;
    logic             full;
    logic             empty;
    logic [PTR_W:0]   count;
    logic             wr_data;
    logic             wr_ctrl;
    logic [15:0]      status;

    assign wr_data = bus.bus_wr && (bus.bus_addr == ADDR_DATA);
    assign wr_ctrl = bus.bus_wr && (bus.bus_addr == ADDR_CTRL);

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_data),
        .pop   (load),
        .flush (wr_ctrl && bus.bus_wdata[CTRL_FLUSH]),
        .din   (bus.bus_wdata),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= next_state;
            tmo_cnt <= tmo_next;
        end
    end

    // A transmitter that never raises busy is assumed to have taken the byte.
    always_comb begin
        next_state = state;
        tmo_next   = tmo_cnt;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !bus.tx_busy) begin
                    load       = 1'b1;
                    tmo_next   = '0;
                    next_state = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    next_state = WAIT_DONE;
                end else begin
                    tmo_next = tmo_cnt + CNT_W'(1);
                    if (tmo_cnt == CNT_W'(ACK_TIMEOUT - 1)) next_state = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_en_q <= 1'b0;
            data_q     <= '0;
        end else begin
            write_en_q <= load;
            if (load) data_q <= head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_data && full) begin
            overflow <= 1'b1;
        end else if (wr_ctrl && bus.bus_wdata[CTRL_CLR_OVF]) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        status           = '0;
        status[15:8]     = 8'(count);
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
        status[ST_BUSY]  = bus.tx_busy;
        status[ST_OVF]   = overflow;
        status[ST_DRAIN] = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (bus.bus_rd) begin
            rdata_q <= (bus.bus_addr == ADDR_STATUS) ? status : 16'h0000;
        end
    end

    assign bus.tx_write_en = write_en_q;
    assign bus.tx_data     = data_q;
    assign bus.bus_rdata   = rdata_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a model transmitter, register driver tasks
// and scoreboards for transmitted bytes and register reads.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;

  always #5 clk = ~clk;

  uart_tx_fifo_if bus_if();

  uart_tx_fifo #(.DEPTH(16), .ACK_TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  int          pulse_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] rd_q[$];
  logic        rd_flag = 1'b0;
  logic        prev_we = 1'b0;
  logic        busy_n1 = 1'b0;

  // model transmitter controls: mode 0 = responds to pulses, 1 = held at hold_val
  int   mode = 0;
  logic hold_val = 1'b0;
  int   busy_len = 8;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model transmitter ----------------
  initial begin
    logic we_s;
    bus_if.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      we_s = bus_if.tx_write_en;
      @(posedge clk);
      #1;
      if (mode == 1) begin
        bus_if.tx_busy = hold_val;
      end else begin
        if (we_s) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
        bus_if.tx_busy = (busy_cnt != 0);
      end
    end
  end

  // ---------------- monitor ----------------
  always @(posedge clk) rd_flag <= bus_if.bus_rd;

  always @(negedge clk) begin
    if (rd_flag) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdata: unexpected read data 0x%0h", bus_if.bus_rdata);
      end else begin
        check("rdata", bus_if.bus_rdata, rd_q.pop_front());
      end
    end
    if (bus_if.tx_write_en) begin
      pulse_cnt++;
      check("pulse_width", prev_we, 1'b0);
      check("busy_low_before_pulse", busy_n1, 1'b0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_data: unexpected pulse with data 0x%0h", bus_if.tx_data);
      end else begin
        check("tx_data", bus_if.tx_data, exp_q.pop_front());
      end
    end
    prev_we = bus_if.tx_write_en;
    busy_n1 = bus_if.tx_busy;
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [7:0] data);
    bus_if.bus_wr    = 1'b1;
    bus_if.bus_addr  = addr;
    bus_if.bus_wdata = data;
    @(negedge clk);
    bus_if.bus_wr = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] addr, input logic [15:0] exp);
    bus_if.bus_rd   = 1'b1;
    bus_if.bus_addr = addr;
    rd_q.push_back(exp);
    @(negedge clk);
    bus_if.bus_rd = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int limit, input string name);
    int n = 0;
    while (bus_if.tx_busy !== val && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, bus_if.tx_busy, val);
  endtask

  task automatic wait_sent(input int limit, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int p0;
    bus_if.bus_wr    = 1'b0;
    bus_if.bus_rd    = 1'b0;
    bus_if.bus_addr  = 2'd0;
    bus_if.bus_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_write_en", bus_if.tx_write_en, 1'b0);
    check("rst_tx_data", bus_if.tx_data, 8'h00);
    check("rst_rdata", bus_if.bus_rdata, 16'h0000);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;

    // 1: idle status, no spurious pulses
    do_read(ADDR_STATUS, 16'h0001);
    p0 = pulse_cnt;
    idle(20);
    check("t1_no_pulse", pulse_cnt - p0, 0);

    // 2: single byte, draining visible for the whole busy window
    busy_len = 100;
    exp_q.push_back(8'h41);
    do_write(ADDR_DATA, 8'h41);
    wait_busy(1'b1, 10, "t2_busy_rise");
    for (int k = 0; k < 200; k++) begin
      if (!bus_if.tx_busy) break;
      if (k % 16 == 0) do_read(ADDR_STATUS, 16'h0015);
      else idle(1);
    end
    do_read(ADDR_STATUS, 16'h0011);
    do_read(ADDR_STATUS, 16'h0001);
    check("t2_sent", exp_q.size(), 0);

    // 3: three queued bytes drain in order, count steps down
    busy_len = 6;
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h69);
    exp_q.push_back(8'h21);
    do_write(ADDR_DATA, 8'h48);
    do_write(ADDR_DATA, 8'h69);
    do_write(ADDR_DATA, 8'h21);
    wait_busy(1'b1, 20, "t3_busy1");
    do_read(ADDR_STATUS, 16'h0214);
    wait_busy(1'b0, 40, "t3_idle1");
    wait_busy(1'b1, 20, "t3_busy2");
    do_read(ADDR_STATUS, 16'h0114);
    wait_busy(1'b0, 40, "t3_idle2");
    wait_busy(1'b1, 20, "t3_busy3");
    do_read(ADDR_STATUS, 16'h0015);
    wait_busy(1'b0, 40, "t3_idle3");
    idle(5);
    check("t3_sent", exp_q.size(), 0);

    // 4: overfill while the transmitter is held busy
    mode = 1;
    hold_val = 1'b1;
    idle(2);
    for (int i = 0; i < 17; i++) do_write(ADDR_DATA, 8'h10 + 8'(i));
    do_read(ADDR_STATUS, 16'h100E);
    do_write(ADDR_CTRL, 8'h02);
    do_read(ADDR_STATUS, 16'h1006);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
    busy_len = 4;
    mode = 0;
    wait_sent(600, "t4_drained");
    idle(10);
    do_read(ADDR_STATUS, 16'h0001);

    // 5: flush while a byte is on the line
    busy_len = 30;
    exp_q.push_back(8'hA0);
    for (int i = 0; i < 5; i++) do_write(ADDR_DATA, 8'hA0 + 8'(i));
    wait_busy(1'b1, 20, "t5_busy");
    idle(1);
    check("t5_state", dbg_state, WAIT_DONE);
    p0 = pulse_cnt;
    do_write(ADDR_CTRL, 8'h01);
    do_read(ADDR_STATUS, 16'h0015);
    wait_busy(1'b0, 60, "t5_done");
    idle(20);
    check("t5_no_pulse", pulse_cnt - p0, 0);
    check("t5_sent", exp_q.size(), 0);

    // 6a: transmitter never acknowledges
    mode = 1;
    hold_val = 1'b0;
    idle(2);
    exp_q.push_back(8'h55);
    do_write(ADDR_DATA, 8'h55);
    for (int i = 0; i < 10; i++) begin
      if (bus_if.tx_write_en) break;
      idle(1);
    end
    check("t6_pulse", bus_if.tx_write_en, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t6_wait_ack", dbg_state, WAIT_ACK);
      idle(1);
    end
    check("t6_timeout_idle", dbg_state, IDLE);

    // 6b: reset during WAIT_DONE
    mode = 0;
    busy_len = 50;
    idle(2);
    exp_q.push_back(8'h66);
    do_write(ADDR_DATA, 8'h66);
    do_write(ADDR_DATA, 8'h77);
    wait_busy(1'b1, 20, "t6_busy");
    idle(2);
    check("t6_state", dbg_state, WAIT_DONE);
    do_read(ADDR_STATUS, 16'h0114);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_write_en", bus_if.tx_write_en, 1'b0);
    check("t6_rst_tx_data", bus_if.tx_data, 8'h00);
    check("t6_rst_rdata", bus_if.bus_rdata, 16'h0000);
    check("t6_rst_state", dbg_state, IDLE);
    rst = 1'b0;
    do_read(ADDR_STATUS, 16'h0005);
    p0 = pulse_cnt;
    wait_busy(1'b0, 80, "t6_done");
    idle(10);
    check("t6_no_pulse", pulse_cnt - p0, 0);
    check("t6_sent", exp_q.size(), 0);
    check("reads_consumed", rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
